// File: rtl/gmsk_pkg.sv
// Shared GMSK/GSM definitions: sequencer state encoding, GSM normal-burst
// field lengths and the modulator timing defaults used by gmsk_tx instances.
package gmsk_pkg;

    // Burst sequencer states, in the order a burst walks through them.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_DATA  = 3'd2,
        ST_TRAIL = 3'd3,
        ST_GUARD = 3'd4
    } gmsk_seq_state_t;

    // GSM normal burst field lengths, in symbols.
    localparam int GSM_TAIL_BITS       = 3;
    localparam int GSM_NB_PAYLOAD_BITS = 142;
    localparam int GSM_GUARD_BITS      = 8;

    // Modulator timing shared with gmsk_tx: samples per symbol equals the
    // modulator ROM depth, clocks per sample sets the sample rate.
    localparam int GMSK_SAMPLES_PER_SYMBOL = 32;
    localparam int GMSK_CLOCKS_PER_SAMPLE  = 4;

endpackage

// File: rtl/gmsk_burst_sequencer_if.sv
// Bundle between the burst formatter (master) and the burst sequencer
// (slave), including the sequencer's drive lines into gmsk_tx.
//
// Handshake: a payload bit transfers in a cycle where bit_valid and
// bit_ready are both 1. bit_ready is registered, so it is only raised in
// the fetch cycle when bit_valid was already 1 in the cycle before; a
// source that holds bit_valid and bit_data steady until bit_ready sees
// every bit taken exactly once. A bit that is not offered in time is not
// taken for the current symbol and stays with the source for the next one.
interface gmsk_burst_sequencer_if;
    logic start;
    logic bit_data;
    logic bit_valid;
    logic bit_ready;
    logic symbol_strobe;
    logic sample_strobe;
    logic input_bit;
    logic busy;
    logic done;
    logic underrun;

    modport master (
        output start, bit_data, bit_valid,
        input  bit_ready, symbol_strobe, sample_strobe, input_bit,
               busy, done, underrun
    );

    modport slave (
        input  start, bit_data, bit_valid,
        output bit_ready, symbol_strobe, sample_strobe, input_bit,
               busy, done, underrun
    );
endinterface

// File: rtl/gmsk_strobe_gen.sv
// Symbol/sample timing for the burst sequencer. While run is high the
// position within the symbol advances one clock at a time; launch pins it
// to the first clock of a symbol. All strobes are registered and describe
// the clock that follows the edge at which they are computed.
module gmsk_strobe_gen #(
    parameter int CLOCKS_PER_SAMPLE  = 4,
    parameter int SAMPLES_PER_SYMBOL = 32
) (
    input  logic clock,
    input  logic reset_n,
    input  logic launch,
    input  logic run,
    output logic symbol_strobe,
    output logic sample_strobe,
    output logic symbol_end,
    output logic fetch_window
);

    localparam int CW = $clog2(CLOCKS_PER_SAMPLE);
    localparam int SW = $clog2(SAMPLES_PER_SYMBOL);

    localparam logic [CW-1:0] CLK_LAST = CW'(CLOCKS_PER_SAMPLE - 1);
    localparam logic [CW-1:0] CLK_PRE  = CW'(CLOCKS_PER_SAMPLE - 2);
    localparam logic [SW-1:0] SMP_LAST = SW'(SAMPLES_PER_SYMBOL - 1);

    logic [CW-1:0] clk_cnt;
    logic [SW-1:0] smp_cnt;
    logic [CW-1:0] clk_nxt;
    logic [SW-1:0] smp_nxt;

    // Next position in the symbol: held at zero when idle or launching,
    // otherwise clk_cnt counts within a sample and smp_cnt within a symbol.
    always_comb begin
        clk_nxt = '0;
        smp_nxt = '0;
        if (run && !launch) begin
            if (clk_cnt == CLK_LAST) begin
                clk_nxt = '0;
                smp_nxt = (smp_cnt == SMP_LAST) ? '0 : smp_cnt + 1'b1;
            end else begin
                clk_nxt = clk_cnt + 1'b1;
                smp_nxt = smp_cnt;
            end
        end
    end

    // Counters and strobes decoded from the next position. The sample strobe
    // sits on the last clock of each sample and the symbol strobe on the
    // first, so the two can never coincide while CLOCKS_PER_SAMPLE >= 2.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_cnt       <= '0;
            smp_cnt       <= '0;
            symbol_strobe <= 1'b0;
            sample_strobe <= 1'b0;
            symbol_end    <= 1'b0;
            fetch_window  <= 1'b0;
        end else begin
            clk_cnt       <= clk_nxt;
            smp_cnt       <= smp_nxt;
            symbol_strobe <= run && (clk_nxt == '0) && (smp_nxt == '0);
            sample_strobe <= run && (clk_nxt == CLK_LAST);
            symbol_end    <= run && (clk_nxt == CLK_LAST) && (smp_nxt == SMP_LAST);
            fetch_window  <= run && (clk_nxt == CLK_PRE) && (smp_nxt == SMP_LAST);
        end
    end

endmodule

// File: rtl/gmsk_burst_sequencer.sv
// Frames one GSM normal burst (tail, payload, tail, guard) into gmsk_tx:
// runs the burst FSM, counts symbols per field, pulls payload bits from the
// upstream source and flags underruns. Timing comes from gmsk_strobe_gen.
module gmsk_burst_sequencer
    import gmsk_pkg::*;
#(
    parameter int CLOCKS_PER_SAMPLE  = GMSK_CLOCKS_PER_SAMPLE,
    parameter int SAMPLES_PER_SYMBOL = GMSK_SAMPLES_PER_SYMBOL,
    parameter int TAIL_BITS          = GSM_TAIL_BITS,
    parameter int PAYLOAD_BITS       = GSM_NB_PAYLOAD_BITS,
    parameter int GUARD_BITS         = GSM_GUARD_BITS
) (
    input  logic                   clock,
    input  logic                   reset_n,
    gmsk_burst_sequencer_if.slave  bus,
    output gmsk_seq_state_t        state_dbg
);

    gmsk_seq_state_t state;
    logic [7:0]      sym_cnt;

    logic bit_ready_q;
    logic input_bit_q;
    logic busy_q;
    logic done_q;
    logic underrun_q;

    logic symbol_strobe;
    logic sample_strobe;
    logic symbol_end;
    logic fetch_window;

    logic last_sym;
    logic launch;
    logic final_end;
    logic run;
    logic next_is_data;
    logic next_is_guard;
    logic take;

    // Whether the symbol now on air is the last one of its field.
    always_comb begin
        last_sym = 1'b0;
        case (state)
            ST_LEAD:  last_sym = (sym_cnt == 8'(TAIL_BITS - 1));
            ST_DATA:  last_sym = (sym_cnt == 8'(PAYLOAD_BITS - 1));
            ST_TRAIL: last_sym = (sym_cnt == 8'(TAIL_BITS - 1));
            ST_GUARD: last_sym = (sym_cnt == 8'(GUARD_BITS - 1));
            default:  last_sym = 1'b0;
        endcase
    end

    assign launch        = (state == ST_IDLE) && bus.start;
    assign final_end     = (state == ST_GUARD) && last_sym && symbol_end;
    assign run           = launch || ((state != ST_IDLE) && !final_end);
    assign next_is_data  = ((state == ST_LEAD) && last_sym) ||
                           ((state == ST_DATA) && !last_sym);
    assign next_is_guard = ((state == ST_TRAIL) && last_sym) ||
                           ((state == ST_GUARD) && !last_sym);
    assign take          = bit_ready_q && bus.bit_valid;

    gmsk_strobe_gen #(
        .CLOCKS_PER_SAMPLE  (CLOCKS_PER_SAMPLE),
        .SAMPLES_PER_SYMBOL (SAMPLES_PER_SYMBOL)
    ) u_strobe_gen (
        .clock         (clock),
        .reset_n       (reset_n),
        .launch        (launch),
        .run           (run),
        .symbol_strobe (symbol_strobe),
        .sample_strobe (sample_strobe),
        .symbol_end    (symbol_end),
        .fetch_window  (fetch_window)
    );

    // Burst FSM: field transitions on symbol boundaries, payload fetch in the
    // clock before each DATA symbol, and the next symbol value loaded on the
    // edge that raises symbol_strobe so input_bit holds for a whole symbol.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            sym_cnt     <= '0;
            bit_ready_q <= 1'b0;
            input_bit_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            bit_ready_q <= 1'b0;
            if (state == ST_IDLE) begin
                sym_cnt <= '0;
                if (bus.start) begin
                    state       <= ST_LEAD;
                    busy_q      <= 1'b1;
                    underrun_q  <= 1'b0;
                    input_bit_q <= 1'b0;
                end
            end else begin
                // Offer ready only for a bit that is already being presented.
                if (fetch_window && next_is_data && bus.bit_valid) begin
                    bit_ready_q <= 1'b1;
                end
                if (symbol_end) begin
                    if (last_sym) begin
                        sym_cnt <= '0;
                        case (state)
                            ST_LEAD:  state <= ST_DATA;
                            ST_DATA:  state <= ST_TRAIL;
                            ST_TRAIL: state <= ST_GUARD;
                            default: begin
                                state  <= ST_IDLE;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                            end
                        endcase
                    end else begin
                        sym_cnt <= sym_cnt + 8'd1;
                    end
                    if (next_is_data) begin
                        input_bit_q <= take ? bus.bit_data : 1'b0;
                        if (!take) begin
                            underrun_q <= 1'b1;
                        end
                    end else if (next_is_guard) begin
                        input_bit_q <= 1'b1;
                    end else if (!final_end) begin
                        input_bit_q <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.bit_ready     = bit_ready_q;
    assign bus.symbol_strobe = symbol_strobe;
    assign bus.sample_strobe = sample_strobe;
    assign bus.input_bit     = input_bit_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.underrun      = underrun_q;
    assign state_dbg         = state;

endmodule
